// File: rtl/alu_wide_pkg.sv
// Shared types for the alu_wide ALU and its BFM: op encodings, FSM state,
// debug view and multiplier latency bounds.
package alu_wide_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    sub_op = 3'b101,
    rsv_op = 3'b110,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_1   = 2'd1,
    ST_BUSY_MUL = 2'd2
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [3:0] cnt;
    logic       mul_valid;
  } dbg_t;

  localparam int MUL_LAT_MIN = 2;
  localparam int MUL_LAT_MAX = 8;

  function automatic logic is_single_cycle(operation_t op);
    return (op == add_op) || (op == and_op) || (op == xor_op) || (op == sub_op);
  endfunction

endpackage

// File: rtl/alu_wide_mul.sv
// Unsigned WIDTH x WIDTH multiplier, LAT register stages deep, with a valid
// shift register that reset clears.
module alu_wide_mul
  import alu_wide_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAT   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_valid,
  output logic [2*WIDTH-1:0]   o_p
);

  logic [2*WIDTH-1:0] r_p [LAT];
  logic [LAT-1:0]     r_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= '0;
    end else begin
      r_v <= {r_v[LAT-2:0], i_valid};
    end
  end

  // Data stages carry no reset; only the valid pipe decides what is live.
  always_ff @(posedge clk) begin
    if (i_valid) begin
      r_p[0] <= {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    end
    for (int k = 1; k < LAT; k++) begin
      r_p[k] <= r_p[k-1];
    end
  end

  assign o_valid = r_v[LAT-1];
  assign o_p     = r_p[LAT-1];

endmodule

// File: rtl/alu_wide.sv
// WIDTH-bit start/done ALU with single-cycle add/and/xor/sub and a MUL_LAT
// pipelined multiply. Define ALU_WIDE_FLAGS_EN to add flag_zero/flag_carry.
module alu_wide
  import alu_wide_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           op,
  input  logic                 start,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
`ifdef ALU_WIDE_FLAGS_EN
  output logic                 flag_zero,
  output logic                 flag_carry,
`endif
  output dbg_t                 o_dbg
);

  localparam logic [3:0] LAT4 = 4'(MUL_LAT);

  if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_bad_lat
    $error("alu_wide: MUL_LAT out of range");
  end

  operation_t         w_op;
  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  operation_t         r_op;
  logic               w_mul_launch;
  logic               w_mul_valid;
  logic [2*WIDTH-1:0] w_mul_p;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_sc_res;

  assign w_op         = operation_t'(op);
  assign w_mul_launch = (r_state == ST_IDLE) && start && (w_op == mul_op);
  assign w_a_ext      = {{WIDTH{1'b0}}, r_a};
  assign w_b_ext      = {{WIDTH{1'b0}}, r_b};

  alu_wide_mul #(
    .WIDTH (WIDTH),
    .LAT   (MUL_LAT)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_mul_launch),
    .i_a     (A),
    .i_b     (B),
    .o_valid (w_mul_valid),
    .o_p     (w_mul_p)
  );

  // Subtraction wraps modulo 2^(2*WIDTH), so a borrow sign-extends.
  always_comb begin
    w_sc_res = '0;
    case (r_op)
      add_op:  w_sc_res = w_a_ext + w_b_ext;
      sub_op:  w_sc_res = w_a_ext - w_b_ext;
      and_op:  w_sc_res = w_a_ext & w_b_ext;
      xor_op:  w_sc_res = w_a_ext ^ w_b_ext;
      default: w_sc_res = '0;
    endcase
  end

`ifdef ALU_WIDE_FLAGS_EN
  logic w_sc_carry;
  assign w_sc_carry = (r_op == add_op) ? w_sc_res[WIDTH] :
                      (r_op == sub_op) ? (r_a < r_b) : 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= no_op;
      done       <= 1'b0;
      result     <= '0;
`ifdef ALU_WIDE_FLAGS_EN
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && is_single_cycle(w_op)) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= w_op;
            r_state <= ST_BUSY_1;
          end else if (start && (w_op == mul_op)) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= w_op;
            r_cnt   <= 4'd1;
            r_state <= ST_BUSY_MUL;
          end
        end
        ST_BUSY_1: begin
          result     <= w_sc_res;
          done       <= 1'b1;
          r_state    <= ST_IDLE;
`ifdef ALU_WIDE_FLAGS_EN
          flag_zero  <= (w_sc_res == '0);
          flag_carry <= w_sc_carry;
`endif
        end
        ST_BUSY_MUL: begin
          // cnt is 1 after the sampling edge, so this fires MUL_LAT edges later.
          if (r_cnt == LAT4) begin
            result     <= w_mul_p;
            done       <= 1'b1;
            r_state    <= ST_IDLE;
`ifdef ALU_WIDE_FLAGS_EN
            flag_zero  <= (w_mul_p == '0);
            flag_carry <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_dbg.state     = r_state;
  assign o_dbg.cnt       = r_cnt;
  assign o_dbg.mul_valid = w_mul_valid;

endmodule

// File: tb/tb_alu_wide.sv
// Directed bench for alu_wide: 8-bit/MUL_LAT=3 and 16-bit/MUL_LAT=5 instances,
// expected results and done cycles queued by the drivers, checked by monitors.
module tb_alu_wide;
  import alu_wide_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  // 8-bit instance
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [2:0]  op = '0;
  logic        start = 1'b0;
  logic        done;
  logic [15:0] result;
  dbg_t        dbg8;
  logic        flag_zero;
  logic        flag_carry;

  // 16-bit instance
  logic [15:0] A16 = '0;
  logic [15:0] B16 = '0;
  logic [2:0]  op16 = '0;
  logic        start16 = 1'b0;
  logic        done16;
  logic [31:0] result16;
  dbg_t        dbg16;
  logic        flag_zero16;
  logic        flag_carry16;

  // {zero, carry, result}
  logic [17:0] exp_q[$];
  int          cyc_q[$];
  logic [31:0] exp16_q[$];
  int          cyc16_q[$];
  logic [15:0] last_res = '0;

  alu_wide #(.WIDTH(8), .MUL_LAT(3)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .A          (A),
    .B          (B),
    .op         (op),
    .start      (start),
    .done       (done),
    .result     (result),
`ifdef ALU_WIDE_FLAGS_EN
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
`endif
    .o_dbg      (dbg8)
  );

  alu_wide #(.WIDTH(16), .MUL_LAT(5)) u_dut16 (
    .clk        (clk),
    .reset      (reset),
    .A          (A16),
    .B          (B16),
    .op         (op16),
    .start      (start16),
    .done       (done16),
    .result     (result16),
`ifdef ALU_WIDE_FLAGS_EN
    .flag_zero  (flag_zero16),
    .flag_carry (flag_carry16),
`endif
    .o_dbg      (dbg16)
  );

`ifndef ALU_WIDE_FLAGS_EN
  assign flag_zero    = 1'b0;
  assign flag_carry   = 1'b0;
  assign flag_zero16  = 1'b0;
  assign flag_carry16 = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver: call at a negedge; returns at the negedge where done was seen
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                       input logic [15:0] exp_r, input logic ez, input logic ec,
                       input int lat, input int mode, input bit hold);
    bit got;
    A = a; B = b; op = o; start = 1'b1;
    exp_q.push_back({ez, ec, exp_r});
    cyc_q.push_back(cyc + 1 + lat);
    last_res = exp_r;
    @(negedge clk);
    if (mode == 2) start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (mode == 1) begin
          A = 8'($urandom_range(0, 255));
          B = 8'($urandom_range(0, 255));
          op = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
      end
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout actual=no_done required=done op=%0d", o);
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                         input logic [31:0] exp_r, input int lat);
    bit got;
    A16 = a; B16 = b; op16 = o; start16 = 1'b1;
    exp16_q.push_back(exp_r);
    cyc16_q.push_back(cyc + 1 + lat);
    @(negedge clk);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done16) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL done16_timeout actual=no_done required=done");
    end
    start16 = 1'b0;
  endtask

  // scoreboard monitor, 8-bit instance
  initial begin
    logic        prev_done;
    logic [17:0] e;
    int          c;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("done_not_consecutive", {63'd0, prev_done}, 64'd0);
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL spurious_done actual=%0h required=no_done", result);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          chk("result", {48'd0, result}, {48'd0, e[15:0]});
          chk("latency_cycle", 64'(cyc), 64'(c));
`ifdef ALU_WIDE_FLAGS_EN
          chk("flag_zero", {63'd0, flag_zero}, {63'd0, e[17]});
          chk("flag_carry", {63'd0, flag_carry}, {63'd0, e[16]});
`endif
        end
      end
      prev_done = done;
    end
  end

  // scoreboard monitor, 16-bit instance
  initial begin
    logic [31:0] e;
    int          c;
    forever begin
      @(negedge clk);
      if (done16) begin
        if (exp16_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL spurious_done16 actual=%0h required=no_done", result16);
        end else begin
          e = exp16_q.pop_front();
          c = cyc16_q.pop_front();
          chk("result16", {32'd0, result16}, {32'd0, e});
          chk("latency16_cycle", 64'(cyc), 64'(c));
        end
      end
    end
  end

  initial begin
    logic [2:0] noops[3];
    noops[0] = 3'b000; noops[1] = 3'b110; noops[2] = 3'b111;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_result", {48'd0, result}, 64'd0);
    chk("reset_state", {62'd0, dbg8.state}, {62'd0, ST_IDLE});
    chk("reset_result16", {32'd0, result16}, 64'd0);
    chk("reset_flags", {62'd0, flag_zero, flag_carry}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // a, b, op, result, zero, carry, latency, mode, hold
    issue(8'hFF, 8'h01, add_op, 16'h0100, 1'b0, 1'b1, 1, 0, 1'b0);
    @(negedge clk);
    issue(8'h01, 8'h02, sub_op, 16'hFFFF, 1'b0, 1'b1, 1, 0, 1'b0);
    issue(8'h05, 8'h05, sub_op, 16'h0000, 1'b1, 1'b0, 1, 0, 1'b0);
    issue(8'hA5, 8'h3C, and_op, 16'h0024, 1'b0, 1'b0, 1, 0, 1'b0);
    issue(8'hA5, 8'h3C, xor_op, 16'h0099, 1'b0, 1'b0, 1, 0, 1'b0);
    issue(8'hFF, 8'hFF, mul_op, 16'hFE01, 1'b0, 1'b0, 3, 1, 1'b0);
    issue(8'h0C, 8'h0D, mul_op, 16'h009C, 1'b0, 1'b0, 3, 2, 1'b0);
    issue(8'h00, 8'hFF, mul_op, 16'h0000, 1'b1, 1'b0, 3, 0, 1'b0);
    issue(8'h7F, 8'h01, add_op, 16'h0080, 1'b0, 1'b0, 1, 0, 1'b0);

    // no_op-class ops held high: nothing happens
    for (int k = 0; k < 3; k++) begin
      A = 8'h11; B = 8'h22; op = noops[k]; start = 1'b1;
      repeat (4) @(negedge clk);
      start = 1'b0;
      chk("noop_result", {48'd0, result}, {48'd0, last_res});
      chk("noop_state", {62'd0, dbg8.state}, {62'd0, ST_IDLE});
    end

    // reset one edge into a multiply discards it
    A = 8'h12; B = 8'h34; op = mul_op; start = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_result", {48'd0, result}, 64'd0);
    chk("abort_state", {62'd0, dbg8.state}, {62'd0, ST_IDLE});
    chk("abort_mul_valid", {63'd0, dbg8.mul_valid}, 64'd0);
    issue(8'h03, 8'h04, add_op, 16'h0007, 1'b0, 1'b0, 1, 0, 1'b0);

    // back-to-back with start held throughout
    @(negedge clk);
    issue(8'h10, 8'h20, add_op, 16'h0030, 1'b0, 1'b0, 1, 0, 1'b1);
    issue(8'hF0, 8'h0F, xor_op, 16'h00FF, 1'b0, 1'b0, 1, 0, 1'b0);

    // 16-bit, MUL_LAT=5
    issue16(16'hFFFF, 16'hFFFF, mul_op, 32'hFFFE0001, 5);
    issue16(16'hFFFF, 16'h0001, add_op, 32'h00010000, 1);
    issue16(16'h0001, 16'h0002, sub_op, 32'hFFFFFFFF, 1);

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("exp16_q_drained", 64'(exp16_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
